// File: rtl/de_stage.sv
// rtl/de_stage.sv - RV32I decode stage: decode, register file, writer scoreboard, DE latch (optional DE_WB_BYPASS_EN)
module de_stage #(
  parameter int DBITS = 32,
  parameter int CNTW  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [128:0] fe_latch_in,
  input  logic         agex_flush,
  input  logic [37:0]  from_WB_to_DE,
  output logic         from_DE_to_FE,
  output logic [212:0] de_latch_out
);

`ifdef DE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [3:0] OP_NOP = 4'd0, OP_LUI = 4'd1, OP_AUIPC = 4'd2, OP_JAL = 4'd3,
                         OP_JALR = 4'd4, OP_BRANCH = 4'd5, OP_LOAD = 4'd6, OP_STORE = 4'd7,
                         OP_OPIMM = 4'd8, OP_OP = 4'd9;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic             fe_valid;
  logic [31:0]      inst;
  logic [DBITS-1:0] fe_pc, fe_pcplus;
  logic [31:0]      inst_count;
  logic             wb_en;
  logic [4:0]       wb_reg;
  logic [DBITS-1:0] wb_data;

  assign fe_valid   = fe_latch_in[128];
  assign inst       = fe_latch_in[127:96];
  assign fe_pc      = fe_latch_in[95:64];
  assign fe_pcplus  = fe_latch_in[63:32];
  assign inst_count = fe_latch_in[31:0];
  assign wb_en      = from_WB_to_DE[37];
  assign wb_reg     = from_WB_to_DE[36:32];
  assign wb_data    = from_WB_to_DE[31:0];

  logic [DBITS-1:0] rf  [32];
  logic [CNTW-1:0]  cnt [32];

  logic [3:0]       op;
  logic [31:0]      imm;
  logic             rs1_use, rs2_use, writes, wr_en;
  logic [4:0]       rs1, rs2, rd, rs2_num;
  logic             rs1_ready, rs2_ready, wb_hit1, wb_hit2, stall, issue;
  logic [DBITS-1:0] rs1_val, rs2_val;

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  // Classify the opcode and build the sign-extended immediate for its format
  always_comb begin
    op      = OP_NOP;
    imm     = '0;
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    writes  = 1'b0;
    case (inst[6:0])
      7'b0110111: begin op = OP_LUI;    imm = {inst[31:12], 12'b0}; writes = 1'b1; end
      7'b0010111: begin op = OP_AUIPC;  imm = {inst[31:12], 12'b0}; writes = 1'b1; end
      7'b1101111: begin
        op = OP_JAL; writes = 1'b1;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b1100111: begin
        op = OP_JALR; writes = 1'b1; rs1_use = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'b1100011: begin
        op = OP_BRANCH; rs1_use = 1'b1; rs2_use = 1'b1;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0000011: begin
        op = OP_LOAD; writes = 1'b1; rs1_use = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        op = OP_STORE; rs1_use = 1'b1; rs2_use = 1'b1;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b0010011: begin
        op = OP_OPIMM; writes = 1'b1; rs1_use = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0110011: begin op = OP_OP; writes = 1'b1; rs1_use = 1'b1; rs2_use = 1'b1; end
      default: ;
    endcase
  end

  assign wr_en   = writes && (inst[11:7] != 5'd0);
  assign rd      = wr_en ? inst[11:7] : 5'd0;
  assign rs2_num = rs2_use ? rs2 : 5'd0;

  // A WB write to a source register can stand in for the register file only when bypass is built in
  assign wb_hit1 = BYPASS && wb_en && (wb_reg == rs1);
  assign wb_hit2 = BYPASS && wb_en && (wb_reg == rs2);

  // Source readiness, hazard stall and issue decision
  always_comb begin
    rs1_ready = !rs1_use || (rs1 == 5'd0) || (cnt[rs1] == '0) || (wb_hit1 && cnt[rs1] == CNT_ONE);
    rs2_ready = !rs2_use || (rs2 == 5'd0) || (cnt[rs2] == '0) || (wb_hit2 && cnt[rs2] == CNT_ONE);
    stall     = fe_valid && !agex_flush &&
                (!rs1_ready || !rs2_ready || (wr_en && cnt[rd] == CNT_MAX));
    issue     = fe_valid && !stall && !agex_flush;
  end

  // Operand values: zero for unused sources and x0, otherwise bypass or register file
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_use && rs1 != 5'd0) rs1_val = wb_hit1 ? wb_data : rf[rs1];
    if (rs2_use && rs2 != 5'd0) rs2_val = wb_hit2 ? wb_data : rf[rs2];
  end

  assign from_DE_to_FE = stall;

  // Register file write from WB; x0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) rf[r] <= '0;
    end else if (wb_en && wb_reg != 5'd0) begin
      rf[wb_reg] <= wb_data;
    end
  end

  // Outstanding-writer counters: increment on issue, decrement on WB, cancel when both hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue && wr_en && rd == 5'(r)) begin
          if (!(wb_en && wb_reg == 5'(r))) cnt[r] <= cnt[r] + CNT_ONE;
        end else if (wb_en && wb_reg == 5'(r) && cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // DE latch: decoded instruction on issue, bubble otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_latch_out <= '0;
    end else if (issue) begin
      de_latch_out <= {1'b1, op, rd, wr_en, imm, rs1_val, rs2_val, fe_pc, fe_pcplus,
                       rs2_num, 5'b0, inst_count};
    end else begin
      de_latch_out <= '0;
    end
  end

endmodule

// File: tb/tb_de_stage.sv
// tb/tb_de_stage.sv - self-checking bench for de_stage (honours DE_WB_BYPASS_EN)
module tb_de_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic [128:0] fe;
  logic         flush;
  logic [37:0]  wb;
  logic         stall;
  logic [212:0] de;

  always #5 clk = ~clk;

  de_stage dut (
    .clk(clk), .reset(reset), .fe_latch_in(fe), .agex_flush(flush),
    .from_WB_to_DE(wb), .from_DE_to_FE(stall), .de_latch_out(de)
  );

  int tests = 0;
  int fails = 0;
  int seq = 0;
  logic [212:0] expq[$];

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic [4:0]  rs2n;
  } vec_t;
  vec_t tbl[12];

  localparam logic [31:0] ADDI_X1    = 32'h00500093;
  localparam logic [31:0] ADD_X2     = 32'h00108133;
  localparam logic [31:0] ADDI_X3    = 32'h00100193;
  localparam logic [31:0] ADDI_X4    = 32'h00100213;
  localparam logic [31:0] ADDI_X5_X4 = 32'h00020293;
  localparam logic [31:0] ADDI_X6    = 32'h00100313;
  localparam logic [31:0] ADD_X5     = 32'h007302B3;
  localparam logic [31:0] ADDI_X8_X5 = 32'h00028413;

  task automatic chk(input string nm, input logic [212:0] act, input logic [212:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive FE/WB, check stall, queue expected latch, then compare after the edge
  task automatic step(input string nm, input logic fv, input logic [31:0] inst, input logic fl,
                      input logic [37:0] w, input logic exp_stall, input logic iss,
                      input logic [3:0] op, input logic [4:0] rd, input logic we,
                      input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [4:0] rs2n);
    logic [31:0] pc;
    logic [212:0] got;
    pc    = 32'h1000 + 32'(seq) * 4;
    fe    = {fv, inst, pc, pc + 32'd4, 32'(seq)};
    flush = fl;
    wb    = w;
    #1;
    chk({nm, "_stall"}, 213'(stall), 213'(exp_stall));
    expq.push_back(iss ? {1'b1, op, rd, we, imm, r1, r2, pc, pc + 32'd4, rs2n, 5'b0, 32'(seq)}
                       : 213'b0);
    @(posedge clk);
    #1;
    if (expq.size() == 0) begin
      chk({nm, "_queue"}, 213'd0, 213'd1);
    end else begin
      got = de;
      chk({nm, "_latch"}, got, expq.pop_front());
    end
    seq++;
  endtask

  task automatic do_reset();
    fe = '0; flush = 1'b0; wb = '0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'hFE208CE3, 4'd5, 5'd0, 1'b0, 32'hFFFFFFF8, 5'd2};
    tbl[1]  = '{ADDI_X1,      4'd8, 5'd1, 1'b1, 32'd5,        5'd0};
    tbl[2]  = '{32'h00002023, 4'd7, 5'd0, 1'b0, 32'd0,        5'd0};
    tbl[3]  = '{32'h0000007F, 4'd0, 5'd0, 1'b0, 32'd0,        5'd0};
    tbl[4]  = '{32'h123452B7, 4'd1, 5'd5, 1'b1, 32'h12345000, 5'd0};
    tbl[5]  = '{32'hFFFFF317, 4'd2, 5'd6, 1'b1, 32'hFFFFF000, 5'd0};
    tbl[6]  = '{32'hFFDFF3EF, 4'd3, 5'd7, 1'b1, 32'hFFFFFFFC, 5'd0};
    tbl[7]  = '{32'hFFF00467, 4'd4, 5'd8, 1'b1, 32'hFFFFFFFF, 5'd0};
    tbl[8]  = '{32'h01002483, 4'd6, 5'd9, 1'b1, 32'd16,       5'd0};
    tbl[9]  = '{32'h00000033, 4'd9, 5'd0, 1'b0, 32'd0,        5'd0};
    tbl[10] = '{32'h00100013, 4'd8, 5'd0, 1'b0, 32'd1,        5'd0};
    tbl[11] = '{32'hFE002E23, 4'd7, 5'd0, 1'b0, 32'hFFFFFFFC, 5'd0};

    // Reset held with a valid FE instruction: outputs stay zero
    reset = 1'b0; flush = 1'b0; wb = '0;
    fe = {1'b1, ADDI_X1, 32'h0, 32'h4, 32'h0};
    #1;
    chk("rst_stall", 213'(stall), 213'd0);
    chk("rst_latch0", de, 213'd0);
    @(posedge clk); #1;
    chk("rst_latch1", de, 213'd0);
    fe = '0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Decode table
    for (int i = 0; i < 12; i++)
      step("dec", 1'b1, tbl[i].inst, 1'b0, '0, 1'b0, 1'b1, tbl[i].op, tbl[i].rd, tbl[i].we,
           tbl[i].imm, 32'd0, 32'd0, tbl[i].rs2n);

    // RAW hazard on x1
    do_reset();
    step("raw_prod", 1'b1, ADDI_X1, 1'b0, '0, 1'b0, 1'b1, 4'd8, 5'd1, 1'b1, 32'd5, 0, 0, 5'd0);
    step("raw_s0", 1'b1, ADD_X2, 1'b0, '0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step("raw_s1", 1'b1, ADD_X2, 1'b0, '0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DE_WB_BYPASS_EN
    step("raw_wb", 1'b1, ADD_X2, 1'b0, {1'b1, 5'd1, 32'd5}, 1'b0, 1'b1,
         4'd9, 5'd2, 1'b1, 32'd0, 32'd5, 32'd5, 5'd1);
`else
    step("raw_wb", 1'b1, ADD_X2, 1'b0, {1'b1, 5'd1, 32'd5}, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step("raw_go", 1'b1, ADD_X2, 1'b0, '0, 1'b0, 1'b1,
         4'd9, 5'd2, 1'b1, 32'd0, 32'd5, 32'd5, 5'd1);
`endif

    // Counter saturation on x3
    do_reset();
    for (int i = 0; i < 3; i++)
      step("sat_iss", 1'b1, ADDI_X3, 1'b0, '0, 1'b0, 1'b1, 4'd8, 5'd3, 1'b1, 32'd1, 0, 0, 5'd0);
    step("sat_full", 1'b1, ADDI_X3, 1'b0, '0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_wb", 1'b1, ADDI_X3, 1'b0, {1'b1, 5'd3, 32'd7}, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_go", 1'b1, ADDI_X3, 1'b0, '0, 1'b0, 1'b1, 4'd8, 5'd3, 1'b1, 32'd1, 0, 0, 5'd0);

    // Simultaneous issue and WB on x4 keeps cnt[4]=1
    step("sim_iss", 1'b1, ADDI_X4, 1'b0, '0, 1'b0, 1'b1, 4'd8, 5'd4, 1'b1, 32'd1, 0, 0, 5'd0);
    step("sim_both", 1'b1, ADDI_X4, 1'b0, {1'b1, 5'd4, 32'h11}, 1'b0, 1'b1,
         4'd8, 5'd4, 1'b1, 32'd1, 0, 0, 5'd0);
    step("sim_cons", 1'b1, ADDI_X5_X4, 1'b0, '0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DE_WB_BYPASS_EN
    step("sim_wb", 1'b1, ADDI_X5_X4, 1'b0, {1'b1, 5'd4, 32'h22}, 1'b0, 1'b1,
         4'd8, 5'd5, 1'b1, 32'd0, 32'h22, 0, 5'd0);
`else
    step("sim_wb", 1'b1, ADDI_X5_X4, 1'b0, {1'b1, 5'd4, 32'h22}, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step("sim_go", 1'b1, ADDI_X5_X4, 1'b0, '0, 1'b0, 1'b1,
         4'd8, 5'd5, 1'b1, 32'd0, 32'h22, 0, 5'd0);
`endif

    // Flush discards a would-stall instruction without touching the scoreboard
    do_reset();
    step("fl_prod", 1'b1, ADDI_X6, 1'b0, '0, 1'b0, 1'b1, 4'd8, 5'd6, 1'b1, 32'd1, 0, 0, 5'd0);
    step("fl_kill", 1'b1, ADD_X5, 1'b1, '0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step("fl_hold", 1'b1, ADD_X5, 1'b0, '0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    step("fl_x5", 1'b1, ADDI_X8_X5, 1'b0, '0, 1'b0, 1'b1, 4'd8, 5'd8, 1'b1, 32'd0, 0, 0, 5'd0);

    // Reset in the middle of a stall
    do_reset();
    step("mr_prod", 1'b1, ADDI_X1, 1'b0, '0, 1'b0, 1'b1, 4'd8, 5'd1, 1'b1, 32'd5, 0, 0, 5'd0);
    fe = {1'b1, ADD_X2, 32'h2000, 32'h2004, 32'd99};
    #1;
    chk("mr_stall", 213'(stall), 213'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_stall_rst", 213'(stall), 213'd0);
    chk("mr_latch_rst", de, 213'd0);
    @(posedge clk);
    fe = '0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    step("mr_after", 1'b1, ADD_X2, 1'b0, '0, 1'b0, 1'b1,
         4'd9, 5'd2, 1'b1, 32'd0, 32'd0, 32'd0, 5'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
